// File: rtl/i2c_sda_master.sv
// i2c_sda_master: SDA-side I2C master sequencer (START, address, command write, multi-byte read, STOP) paced by sensed SCL edges.
module i2c_sda_master #(
   parameter logic [6:0] SLAVE_ADDR = 7'h44,
   parameter int         RX_MAX     = 6,
   parameter int         STOP_HOLD  = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start_Req,
   input  logic                  Rd_Wr,
   input  logic [7:0]            Cmd_Byte,
   input  logic [2:0]            Rx_Len,
   input  logic [2:0]            Scl_State_Out,
   input  logic                  Scl_Data,
   inout  wire                   Sda_Data,
   output logic [2:0]            Master_State_Out,
   output logic [8*RX_MAX-1:0]   Rx_Data,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Nack_Err
);
   typedef enum logic [2:0] {
      S_PROC  = 3'b000,
      S_START = 3'b001,
      S_ADDR  = 3'b010,
      S_RECV  = 3'b011,
      S_WRITE = 3'b100,
      S_ACK   = 3'b101,
      S_END   = 3'b110
   } state_t;
   localparam int         RW    = 8 * RX_MAX;
   localparam int         IW    = $clog2(RW);
   localparam int         HW    = $clog2(STOP_HOLD + 1);
   localparam logic [2:0] L_MAX = 3'(RX_MAX);
   state_t          r_state, w_state_n, r_from, w_from_n;
   logic            r_scl_prev, r_sda_low, w_sda_n;
   logic [7:0]      r_shift, w_shift_n, r_cmd, w_cmd_n;
   logic [3:0]      r_cnt, w_cnt_n;
   logic [2:0]      r_idx, w_idx_n, r_len, w_len_n;
   logic            r_rd, w_rd_n, r_busy, w_busy_n, r_done, w_done_n;
   logic            r_nack, w_nack_n, r_ack_bit, w_ack_bit_n;
   logic [RW-1:0]   r_rx, w_rx_n;
   logic [HW-1:0]   r_hold, w_hold_n;
   logic            w_rise, w_fall, w_sda_in, w_more;
   logic [7:0]      w_byte;
   logic [IW-1:0]   w_top;
   assign w_rise   = !r_scl_prev && Scl_Data;
   assign w_fall   = r_scl_prev && !Scl_Data;
   assign w_sda_in = Sda_Data;
   assign w_byte   = {r_shift[6:0], w_sda_in};
   assign w_more   = r_idx < r_len;
   assign w_top    = IW'(RW - 1 - 8 * int'(r_idx));
   assign Sda_Data = r_sda_low ? 1'b0 : 1'bz;
   assign Master_State_Out = r_state;
   assign Rx_Data  = r_rx;
   assign Busy     = r_busy;
   assign Done     = r_done;
   assign Nack_Err = r_nack;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_PROC;
         r_from     <= S_PROC;
         r_scl_prev <= 1'b1;
         r_sda_low  <= 1'b0;
         r_shift    <= '0;
         r_cmd      <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_len      <= '0;
         r_rd       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_nack     <= 1'b0;
         r_ack_bit  <= 1'b0;
         r_rx       <= '0;
         r_hold     <= '0;
      end else begin
         r_state    <= w_state_n;
         r_from     <= w_from_n;
         r_scl_prev <= Scl_Data;
         r_sda_low  <= w_sda_n;
         r_shift    <= w_shift_n;
         r_cmd      <= w_cmd_n;
         r_cnt      <= w_cnt_n;
         r_idx      <= w_idx_n;
         r_len      <= w_len_n;
         r_rd       <= w_rd_n;
         r_busy     <= w_busy_n;
         r_done     <= w_done_n;
         r_nack     <= w_nack_n;
         r_ack_bit  <= w_ack_bit_n;
         r_rx       <= w_rx_n;
         r_hold     <= w_hold_n;
      end
   end
   always_comb begin
      w_state_n   = r_state;
      w_from_n    = r_from;
      w_sda_n     = r_sda_low;
      w_shift_n   = r_shift;
      w_cmd_n     = r_cmd;
      w_cnt_n     = r_cnt;
      w_idx_n     = r_idx;
      w_len_n     = r_len;
      w_rd_n      = r_rd;
      w_busy_n    = r_busy;
      w_done_n    = 1'b0;
      w_nack_n    = r_nack;
      w_ack_bit_n = r_ack_bit;
      w_rx_n      = r_rx;
      w_hold_n    = r_hold;
      case (r_state)
         S_PROC: begin
            w_sda_n = 1'b0;
            // a request coinciding with the Done pulse is dropped
            if (Start_Req && !r_busy && !r_done) begin
               w_rd_n    = Rd_Wr;
               w_cmd_n   = Cmd_Byte;
               w_len_n   = (Rx_Len == 3'd0) ? 3'd1 : (Rx_Len > L_MAX) ? L_MAX : Rx_Len;
               w_nack_n  = 1'b0;
               w_busy_n  = 1'b1;
               w_idx_n   = '0;
               w_cnt_n   = '0;
               w_hold_n  = '0;
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (Scl_Data) w_sda_n = 1'b1;
            if (Scl_State_Out == 3'b001) begin
               w_shift_n = {SLAVE_ADDR, r_rd};
               w_sda_n   = !SLAVE_ADDR[6];
               w_cnt_n   = '0;
               w_state_n = S_ADDR;
            end
         end
         S_ADDR, S_WRITE: begin
            if (w_fall && r_cnt < 4'd7) begin
               w_shift_n = {r_shift[6:0], 1'b0};
               w_sda_n   = !r_shift[6];
               w_cnt_n   = r_cnt + 4'd1;
            end else if (w_fall && r_cnt == 4'd7) begin
               w_sda_n = 1'b0;
               w_cnt_n = 4'd8;
            end else if (w_rise && r_cnt == 4'd8) begin
               w_ack_bit_n = w_sda_in;
               w_from_n    = r_state;
               w_state_n   = S_ACK;
            end
         end
         S_RECV: begin
            w_sda_n = 1'b0;
            if (w_rise) begin
               w_shift_n = w_byte;
               w_cnt_n   = r_cnt + 4'd1;
               if (r_cnt == 4'd7) begin
                  w_rx_n[w_top -: 8] = w_byte;
                  w_idx_n   = r_idx + 3'd1;
                  w_cnt_n   = '0;
                  w_from_n  = S_RECV;
                  w_state_n = S_ACK;
               end
            end
         end
         S_ACK: begin
            // after a received byte r_cnt tracks the 8th fall (drive ACK/NACK) then the 9th (release)
            if (r_from == S_RECV) begin
               if (w_fall && r_cnt == 4'd0) begin
                  w_sda_n = w_more;
                  w_cnt_n = 4'd1;
               end else if (w_fall) begin
                  w_sda_n   = 1'b0;
                  w_cnt_n   = '0;
                  w_state_n = w_more ? S_RECV : S_END;
               end
            end else if (w_fall && Scl_State_Out == 3'b010) begin
               w_cnt_n = '0;
               if (r_ack_bit) begin
                  w_nack_n  = 1'b1;
                  w_state_n = S_END;
               end else if (r_from == S_ADDR && r_rd) begin
                  w_state_n = S_RECV;
               end else if (r_from == S_ADDR) begin
                  w_shift_n = r_cmd;
                  w_sda_n   = !r_cmd[7];
                  w_state_n = S_WRITE;
               end else begin
                  w_state_n = S_END;
               end
            end
         end
         S_END: begin
            if (!Scl_Data) w_sda_n = 1'b1;
            if (r_sda_low && Scl_Data) begin
               if (r_hold == HW'(STOP_HOLD - 1)) begin
                  w_sda_n   = 1'b0;
                  w_hold_n  = '0;
                  w_busy_n  = 1'b0;
                  w_done_n  = 1'b1;
                  w_state_n = S_PROC;
               end else begin
                  w_hold_n = r_hold + HW'(1);
               end
            end else begin
               w_hold_n = '0;
            end
         end
         default: w_state_n = S_PROC;
      endcase
   end
endmodule

// File: tb/tb_i2c_sda_master.sv
// tb_i2c_sda_master: directed bench playing SCL generator and SHT40 slave around i2c_sda_master.
module tb_i2c_sda_master;
   logic        clk = 1'b0, rst = 1'b1, Start_Req = 1'b0, Rd_Wr = 1'b0;
   logic        scl = 1'b1, slave_low = 1'b0;
   logic [7:0]  Cmd_Byte = '0;
   logic [2:0]  Rx_Len = '0, sso = '0;
   wire         sda;
   logic [2:0]  mso;
   logic [47:0] rx;
   logic        busy, done, nack;
   int          total = 0, bad = 0;
   logic [7:0]  b;
   logic        a;
   logic [7:0]  d6 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
   logic [7:0]  d7 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;
   always #5 clk = ~clk;
   i2c_sda_master dut (
      .clk(clk), .rst(rst), .Start_Req(Start_Req), .Rd_Wr(Rd_Wr), .Cmd_Byte(Cmd_Byte),
      .Rx_Len(Rx_Len), .Scl_State_Out(sso), .Scl_Data(scl), .Sda_Data(sda),
      .Master_State_Out(mso), .Rx_Data(rx), .Busy(busy), .Done(done), .Nack_Err(nack)
   );
   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask
   task automatic bit_cycle(input logic d0, output logic seen);
      slave_low = d0;
      repeat (3) @(negedge clk);
      scl = 1'b1;
      repeat (3) @(negedge clk);
      seen = sda;
      scl = 1'b0;
      slave_low = 1'b0;
   endtask
   task automatic send_obs(output logic [7:0] o);
      logic s;
      o = '0;
      for (int i = 0; i < 8; i++) begin
         bit_cycle(1'b0, s);
         o = {o[6:0], s};
      end
   endtask
   task automatic ack_slot(input logic d0, output logic seen);
      sso = 3'b010;
      bit_cycle(d0, seen);
      @(negedge clk);
      sso = 3'b001;
   endtask
   task automatic recv_byte(input logic [7:0] d, output logic seen);
      logic s;
      for (int i = 0; i < 8; i++) bit_cycle(!d[7-i], s);
      bit_cycle(1'b0, seen);
      @(negedge clk);
   endtask
   task automatic req(input logic rd, input logic [7:0] cmd, input logic [2:0] len);
      @(negedge clk);
      Rd_Wr = rd; Cmd_Byte = cmd; Rx_Len = len; sso = 3'b000; scl = 1'b1; Start_Req = 1'b1;
      @(negedge clk);
      Start_Req = 1'b0;
      chk("start_state", 48'(mso), 48'd1);
      chk("start_busy", 48'(busy), 48'd1);
      @(negedge clk);
      chk("start_sda", 48'(sda), 48'd0);
      scl = 1'b0;
      repeat (2) @(negedge clk);
      sso = 3'b001;
      @(negedge clk);
      chk("addr_state", 48'(mso), 48'd2);
   endtask
   task automatic stop_seq();
      sso = 3'b011;
      repeat (2) @(negedge clk);
      chk("stop_sda_low", 48'(sda), 48'd0);
      scl = 1'b1;
      repeat (19) @(negedge clk);
      chk("stop_hold_state", 48'(mso), 48'd6);
      chk("stop_hold_sda", 48'(sda), 48'd0);
      @(negedge clk);
      chk("stop_state", 48'(mso), 48'd0);
      chk("stop_done", 48'(done), 48'd1);
      chk("stop_busy", 48'(busy), 48'd0);
      chk("stop_sda_rel", 48'(sda), 48'd1);
      @(negedge clk);
      chk("done_pulse", 48'(done), 48'd0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", 48'(mso), 48'd0);
      chk("rst_sda", 48'(sda), 48'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 48'(busy), 48'd0);
      chk("idle_done", 48'(done), 48'd0);
      chk("idle_nack", 48'(nack), 48'd0);
      chk("idle_rx", rx, 48'd0);
      // write FD with a second request while busy and changed inputs
      req(1'b0, 8'hFD, 3'd0);
      Cmd_Byte = 8'h00; Rd_Wr = 1'b1; Rx_Len = 3'd5; Start_Req = 1'b1;
      @(negedge clk);
      Start_Req = 1'b0;
      send_obs(b);
      chk("wr_addr", 48'(b), 48'h88);
      ack_slot(1'b1, a);
      chk("wr_addr_ack", 48'(a), 48'd0);
      chk("wr_state", 48'(mso), 48'd4);
      send_obs(b);
      chk("wr_cmd", 48'(b), 48'hFD);
      ack_slot(1'b1, a);
      chk("wr_end", 48'(mso), 48'd6);
      chk("wr_nack", 48'(nack), 48'd0);
      stop_seq();
      // address NACK
      req(1'b0, 8'h06, 3'd0);
      send_obs(b);
      chk("nk_addr", 48'(b), 48'h88);
      ack_slot(1'b0, a);
      chk("nk_sda", 48'(a), 48'd1);
      chk("nk_state", 48'(mso), 48'd6);
      chk("nk_flag", 48'(nack), 48'd1);
      stop_seq();
      chk("nk_held", 48'(nack), 48'd1);
      // read 6 bytes
      req(1'b1, 8'h00, 3'd6);
      send_obs(b);
      chk("rd6_addr", 48'(b), 48'h89);
      ack_slot(1'b1, a);
      chk("rd6_state", 48'(mso), 48'd3);
      chk("rd6_nack_clr", 48'(nack), 48'd0);
      for (int i = 0; i < 6; i++) begin
         recv_byte(d6[i], a);
         chk("rd6_mack", 48'(a), (i == 5) ? 48'd1 : 48'd0);
      end
      chk("rd6_end", 48'(mso), 48'd6);
      chk("rd6_rx", rx, 48'h123456789ABC);
      stop_seq();
      // Rx_Len=0 reads one byte
      req(1'b1, 8'h00, 3'd0);
      send_obs(b);
      ack_slot(1'b1, a);
      recv_byte(8'hA5, a);
      chk("rd0_nack", 48'(a), 48'd1);
      chk("rd0_end", 48'(mso), 48'd6);
      chk("rd0_rx", rx, 48'hA53456789ABC);
      stop_seq();
      // Rx_Len=7 clamps to 6
      req(1'b1, 8'h00, 3'd7);
      send_obs(b);
      ack_slot(1'b1, a);
      for (int i = 0; i < 6; i++) begin
         recv_byte(d7[i], a);
         chk("rd7_mack", 48'(a), (i == 5) ? 48'd1 : 48'd0);
      end
      chk("rd7_end", 48'(mso), 48'd6);
      chk("rd7_rx", rx, 48'h112233445566);
      stop_seq();
      // async reset inside the command byte
      req(1'b0, 8'h00, 3'd0);
      send_obs(b);
      ack_slot(1'b1, a);
      chk("rs_state", 48'(mso), 48'd4);
      chk("rs_sda_low", 48'(sda), 48'd0);
      #2 rst = 1'b1;
      #1;
      chk("rs_sda", 48'(sda), 48'd1);
      chk("rs_mso", 48'(mso), 48'd0);
      chk("rs_busy", 48'(busy), 48'd0);
      chk("rs_rx", rx, 48'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rs_idle", 48'(mso), 48'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
